mem_bus_arbiter: RTL

- Shares the single RAM port between the instruction and data caches of two cores.
- Sequences the dual-core snoop phase for coherent data reads, including cache-to-cache forwarding of dirty blocks.
- Sits between the four cache request ports and the RAM model.
- Enforces dcache-over-icache priority and round-robin between cores.

---
 rtl/mem_bus_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - dual-core icache/dcache RAM arbiter with snoop sequencing
module mem_bus_arbiter #(
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [1:0]             iREN,
  input  logic [1:0][WORD_W-1:0] iaddr,
  output logic [1:0]             iwait,
  output logic [1:0][WORD_W-1:0] iload,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0][WORD_W-1:0] daddr,
  input  logic [1:0][WORD_W-1:0] dstore,
  output logic [1:0]             dwait,
  output logic [1:0][WORD_W-1:0] dload,
  input  logic [1:0]             ccwrite,
  input  logic [1:0]             cctrans,
  output logic [1:0]             ccwait,
  output logic [1:0]             ccinv,
  output logic [1:0][WORD_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic                   ramready
);

  typedef enum logic [2:0] {IDLE, DWB, SNOOP, DFWD, DRD, IRD} state_e;

  state_e     state_q, state_d;
  logic       g_q, g_d;
  logic       rr_q, rr_d;
  logic       o;
  logic [1:0] dreq;

  assign o    = ~g_q;
  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_d        = rr_q;
    iwait       = 2'b11;
    dwait       = 2'b11;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state_q)
      IDLE: begin
        // dcache class first; within a class the round-robin core wins if it asks
        if (|dreq) begin
          g_d     = dreq[rr_q] ? rr_q : ~rr_q;
          state_d = dWEN[g_d] ? DWB : SNOOP;
        end else if (|iREN) begin
          g_d     = iREN[rr_q] ? rr_q : ~rr_q;
          state_d = IRD;
        end
      end
      DWB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[g_q];
        ramstore = dstore[g_q];
        if (ramready) begin
          dwait[g_q] = 1'b0;
          state_d    = IDLE;
          rr_d       = o;
        end
      end
      SNOOP: begin
        ccwait[o]      = 1'b1;
        ccsnoopaddr[o] = daddr[g_q];
        ccinv[o]       = ccwrite[g_q];
        if (cctrans[o]) state_d = ccwrite[o] ? DFWD : DRD;
      end
      DFWD: begin
        // dirty block goes to the requester and is written back in the same access
        ccwait[o]  = 1'b1;
        ramWEN     = 1'b1;
        ramaddr    = daddr[o];
        ramstore   = dstore[o];
        dload[g_q] = dstore[o];
        if (ramready) begin
          dwait[g_q] = 1'b0;
          dwait[o]   = 1'b0;
          state_d    = IDLE;
          rr_d       = o;
        end
      end
      DRD: begin
        ramREN     = 1'b1;
        ramaddr    = daddr[g_q];
        dload[g_q] = ramload;
        if (ramready) begin
          dwait[g_q] = 1'b0;
          state_d    = IDLE;
          rr_d       = o;
        end
      end
      IRD: begin
        ramREN     = 1'b1;
        ramaddr    = iaddr[g_q];
        iload[g_q] = ramload;
        if (ramready) begin
          iwait[g_q] = 1'b0;
          state_d    = IDLE;
          rr_d       = o;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
